program_stream_loader: RTL

Parametrised ternary program loader. It accepts instruction words over a valid/ready stream from a host link or bench driver and writes them into ternary instruction memory, starting at a programmable base address. It has an optional read-back verify, a word-count limit, and explicit error reporting. It sits between the host interface and the memory write port and holds the core until `load_complete` is reported.

---
 rtl/program_stream_loader.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/program_stream_loader.sv
// Ternary program loader.
// Takes instruction words from a valid/ready stream and writes them into ternary
// instruction memory. Writes start at a base address and continue at consecutive
// balanced-ternary addresses. Each write can optionally be read back and compared.
//
// Trit encoding: 00 = 0, 01 = +1, 10 = -1, 11 = illegal.
//
// Ports:
//   clock, reset            system clock; asynchronous active-high reset
//   start                   one-cycle pulse, acted on only while idle
//   base_addr, max_words    sampled on start; max_words == 0 means no word limit
//   s_valid/s_data/s_last   input stream; s_ready is driven back
//   mem_addr, mem_write_data, mem_write, mem_read, mem_read_data
//                           memory port; read data arrives one cycle after mem_read
//   busy                    a load is in progress
//   load_complete, error    sticky status flags, cleared by the next accepted start
//   error_code              1 bad base trit, 2 bad data trit, 3 verify mismatch,
//                           4 address overflow
//   words_loaded            number of words committed
module program_stream_loader #(
  parameter int unsigned WORD_SIZE     = 9,
  parameter int unsigned MEM_ADDR_SIZE = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned VERIFY_EN     = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2*MEM_ADDR_SIZE-1:0] base_addr,
  input  logic [CNT_W-1:0]           max_words,
  input  logic                       s_valid,
  input  logic [2*WORD_SIZE-1:0]     s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [2*WORD_SIZE-1:0]     mem_write_data,
  output logic                       mem_write,
  output logic                       mem_read,
  input  logic [2*WORD_SIZE-1:0]     mem_read_data,
  output logic                       busy,
  output logic                       load_complete,
  output logic                       error,
  output logic [2:0]                 error_code,
  output logic [CNT_W-1:0]           words_loaded
);

  localparam int unsigned DW = 2 * WORD_SIZE;
  localparam int unsigned AW = 2 * MEM_ADDR_SIZE;

  // The highest address has every trit at +1.
  localparam logic [AW-1:0] AddrMax = {MEM_ADDR_SIZE{2'b01}};

  localparam logic [2:0] CodeBadAddr  = 3'd1;
  localparam logic [2:0] CodeBadData  = 3'd2;
  localparam logic [2:0] CodeVerify   = 3'd3;
  localparam logic [2:0] CodeOverflow = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StWrite,
    StVrd,
    StVcmp,
    StAdv,
    StDone,
    StError
  } state_e;

  function automatic logic addr_has_illegal(input logic [AW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(MEM_ADDR_SIZE); i++) begin
      if (v[2*i +: 2] == 2'b11) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic data_has_illegal(input logic [DW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(WORD_SIZE); i++) begin
      if (v[2*i +: 2] == 2'b11) bad = 1'b1;
    end
    return bad;
  endfunction

  // Balanced-ternary +1, rippling from the least significant trit.
  // +1 plus 1 becomes -1 and carries; -1 plus 1 becomes 0; 0 plus 1 becomes +1.
  function automatic logic [AW-1:0] tern_inc(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(MEM_ADDR_SIZE); i++) begin
      if (carry) begin
        case (v[2*i +: 2])
          2'b00: begin
            r[2*i +: 2] = 2'b01;
            carry       = 1'b0;
          end
          2'b01: begin
            r[2*i +: 2] = 2'b10;
            carry       = 1'b1;
          end
          default: begin
            r[2*i +: 2] = 2'b00;
            carry       = 1'b0;
          end
        endcase
      end
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      max_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      max_q   <= max_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    max_d   = max_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    cnt_inc = count_q + CNT_W'(1);

    case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = '0;
          count_d = '0;
          max_d   = max_words;
          busy_d  = 1'b1;
          if (addr_has_illegal(base_addr)) begin
            code_d  = CodeBadAddr;
            state_d = StError;
          end else begin
            addr_d  = base_addr;
            state_d = StAccept;
          end
        end
      end
      StAccept: begin
        if (s_valid) begin
          last_d = s_last;
          if (data_has_illegal(s_data)) begin
            code_d  = CodeBadData;
            state_d = StError;
          end else begin
            wdata_d = s_data;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        state_d = (VERIFY_EN != 0) ? StVrd : StAdv;
      end
      StVrd: begin
        state_d = StVcmp;
      end
      StVcmp: begin
        if (mem_read_data != wdata_q) begin
          code_d  = CodeVerify;
          state_d = StError;
        end else begin
          state_d = StAdv;
        end
      end
      StAdv: begin
        count_d = cnt_inc;
        // Finishing takes priority over overflow: a last word at the top address is fine.
        if (last_q || ((max_q != '0) && (cnt_inc == max_q))) begin
          state_d = StDone;
        end else if (addr_q == AddrMax) begin
          code_d  = CodeOverflow;
          state_d = StError;
        end else begin
          addr_d  = tern_inc(addr_q);
          state_d = StAccept;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StError: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The strobes decode straight from the state register. An asynchronous reset
  // therefore drops them immediately.
  assign s_ready        = (state_q == StAccept);
  assign mem_write      = (state_q == StWrite);
  assign mem_read       = (state_q == StVrd);
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = busy_q;
  assign load_complete  = done_q;
  assign error          = err_q;
  assign error_code     = code_q;
  assign words_loaded   = count_q;

endmodule
